// File: rtl/snake_pkg.sv
// Shared definitions for the gesture-to-heading path: heading codes, PAJ7620 gesture
// bytes, controller FSM states and the reversal rule.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] GES_UP    = 8'h01;
  localparam logic [7:0] GES_DOWN  = 8'h02;
  localparam logic [7:0] GES_LEFT  = 8'h04;
  localparam logic [7:0] GES_RIGHT = 8'h08;
  localparam logic [7:0] GES_FWD   = 8'h10;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } fsm_state_e;

  // Opposite headings share bit 1 and differ in bit 0 (up/down, left/right).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/ges_classify.sv
// Combinational split of the raw gesture byte into direction, pause and error classes.
module ges_classify
  import snake_pkg::*;
(
  input  logic [7:0] po_data_i,
  output logic       is_dir_o,
  output logic       is_pause_o,
  output logic       is_err_o,
  output logic [1:0] req_dir_o
);

  logic [3:0] low_nib;
  logic       low_onehot;

  always_comb begin
    low_nib    = po_data_i[3:0];
    low_onehot = (low_nib != 4'd0) && ((low_nib & (low_nib - 4'd1)) == 4'd0);
    is_dir_o   = (po_data_i[7:4] == 4'd0) && low_onehot;
    is_pause_o = (po_data_i == GES_FWD);
    is_err_o   = (po_data_i != 8'd0) && !is_dir_o && !is_pause_o;
    case (po_data_i)
      GES_DOWN:  req_dir_o = DIR_DOWN;
      GES_LEFT:  req_dir_o = DIR_LEFT;
      GES_RIGHT: req_dir_o = DIR_RIGHT;
      default:   req_dir_o = DIR_UP;
    endcase
  end

endmodule

// File: rtl/gesture_dir_ctrl.sv
// Turns PAJ7620 gesture bytes into a validated snake heading: edge-detects gestures,
// drops reversals, queues one turn for the next step tick and toggles pause on forward.
module gesture_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         HOLDOFF_MS = 200,
  parameter logic [1:0] INIT_DIR   = 2'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] po_data,
  input  logic       step_tick,
  input  logic       game_rst,
  output logic [1:0] dir,
  output logic       dir_upd,
  output logic       paused,
  output logic       pend_valid,
  output logic       busy,
  output logic       gesture_err,
  output fsm_state_e dbg_state
);

  localparam int HOLDOFF_CYC = CLK_FREQ / 1000 * HOLDOFF_MS;
  localparam int CNT_W       = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF_CYC - 1);

  // Handshake: none -- step_tick and game_rst are single-cycle strobes sampled on
  // every rising edge; po_data is a level whose changes are edge-detected here.

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_dir_q, pend_dir_d;
  logic             pend_valid_q, pend_valid_d;
  logic             paused_q, paused_d;
  logic             dir_upd_q, dir_upd_d;
  logic             err_q, err_d;
  logic [7:0]       po_d_q;

  logic       cls_is_dir, cls_is_pause, cls_is_err;
  logic [1:0] cls_req_dir;

  ges_classify u_classify (
    .po_data_i  (po_data),
    .is_dir_o   (cls_is_dir),
    .is_pause_o (cls_is_pause),
    .is_err_o   (cls_is_err),
    .req_dir_o  (cls_req_dir)
  );

  logic       gesture_event;
  logic       commit;
  logic [1:0] next_dir;
  logic       dir_ok;
  logic       live_event;
  logic       accept_dir;
  logic       accept_pause;
  logic       flag_err;
  logic       hold_done;

  assign gesture_event = (po_data != po_d_q) && (po_data != 8'd0);
  assign commit        = step_tick && pend_valid_q && !paused_q;
  // Requests are judged against the heading that will be in force after this edge.
  assign next_dir      = commit ? pend_dir_q : dir_q;
  assign dir_ok        = cls_is_dir && !is_reverse(cls_req_dir, next_dir) &&
                         (cls_req_dir != next_dir);
  assign live_event    = !game_rst && (state_q == IDLE) && gesture_event;
  assign accept_dir    = live_event && dir_ok;
  assign accept_pause  = live_event && cls_is_pause;
  assign flag_err      = live_event && cls_is_err;
  assign hold_done     = (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (game_rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept_dir || accept_pause) state_d = HOLDOFF;
        HOLDOFF: if (hold_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == HOLDOFF);
    dbg_state = state_q;
  end

  always_comb begin
    dir_d        = dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    paused_d     = paused_q;
    dir_upd_d    = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    if (game_rst) begin
      dir_d        = INIT_DIR;
      pend_dir_d   = INIT_DIR;
      pend_valid_d = 1'b0;
      paused_d     = 1'b0;
      cnt_d        = '0;
    end else begin
      if (commit) begin
        dir_d        = pend_dir_q;
        pend_valid_d = 1'b0;
        dir_upd_d    = 1'b1;
      end
      // A same-cycle accept re-arms the queue after the old turn commits.
      if (accept_dir) begin
        pend_dir_d   = cls_req_dir;
        pend_valid_d = 1'b1;
      end
      if (accept_pause) paused_d = !paused_q;
      if (flag_err) err_d = 1'b1;
      if (state_q == HOLDOFF) cnt_d = hold_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      dir_q        <= INIT_DIR;
      pend_dir_q   <= INIT_DIR;
      pend_valid_q <= 1'b0;
      paused_q     <= 1'b0;
      dir_upd_q    <= 1'b0;
      err_q        <= 1'b0;
      po_d_q       <= 8'd0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      paused_q     <= paused_d;
      dir_upd_q    <= dir_upd_d;
      err_q        <= err_d;
      po_d_q       <= po_data;
    end
  end

  assign dir         = dir_q;
  assign dir_upd     = dir_upd_q;
  assign paused      = paused_q;
  assign pend_valid  = pend_valid_q;
  assign gesture_err = err_q;

endmodule

// File: tb/tb_gesture_dir_ctrl.sv
// Bench for gesture_dir_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model built from the gesture/turn rules.
module tb_gesture_dir_ctrl;
  import snake_pkg::*;

  localparam int         CLK_FREQ   = 1000;
  localparam int         HOLDOFF_MS = 5;
  localparam int         HOLD_CYC   = CLK_FREQ / 1000 * HOLDOFF_MS;
  localparam logic [1:0] INIT_DIR   = 2'd3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] po_data = 8'h00;
  logic       step_tick = 1'b0;
  logic       game_rst = 1'b0;
  logic [1:0] dir;
  logic       dir_upd, paused, pend_valid, busy, gesture_err;
  fsm_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  gesture_dir_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .HOLDOFF_MS (HOLDOFF_MS),
    .INIT_DIR   (INIT_DIR)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .po_data     (po_data),
    .step_tick   (step_tick),
    .game_rst    (game_rst),
    .dir         (dir),
    .dir_upd     (dir_upd),
    .paused      (paused),
    .pend_valid  (pend_valid),
    .busy        (busy),
    .gesture_err (gesture_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // reference model state
  int         m_dir;
  bit         m_paused;
  int         m_pend[$];
  int         m_hold;
  logic [7:0] m_prev;
  bit         m_upd;
  bit         m_err;
  int         opp[4] = '{1, 0, 3, 2};

  task automatic model_reset();
    m_dir = int'(INIT_DIR);
    m_paused = 0;
    m_pend.delete();
    m_hold = 0;
    m_prev = 8'h00;
    m_upd = 0;
    m_err = 0;
  endtask

  task automatic model_step(input logic [7:0] po, input bit st, input bit gr);
    bit ev;
    bit commit;
    int nd;
    int k;
    ev = (po != m_prev) && (po != 8'h00);
    m_prev = po;
    m_upd = 0;
    m_err = 0;
    if (gr) begin
      m_dir = int'(INIT_DIR);
      m_pend.delete();
      m_paused = 0;
      m_hold = 0;
    end else begin
      commit = st && (m_pend.size() > 0) && !m_paused;
      nd = commit ? m_pend[0] : m_dir;
      if (commit) begin
        m_dir = m_pend.pop_front();
        m_upd = 1;
      end
      if (m_hold > 0) begin
        m_hold--;
      end else if (ev) begin
        if (po < 8'h10 && $countones(po) == 1) begin
          k = $clog2(po);
          if (k != nd && k != opp[nd]) begin
            m_pend.delete();
            m_pend.push_back(k);
            m_hold = HOLD_CYC;
          end
        end else if (po == 8'h10) begin
          m_paused = !m_paused;
          m_hold = HOLD_CYC;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  // drivers
  task automatic drive_cycle(input logic [7:0] po, input bit st, input bit gr);
    po_data = po;
    step_tick = st;
    game_rst = gr;
    model_step(po, st, gr);
    @(posedge sys_clk);
    #1;
    step_tick = 1'b0;
    game_rst = 1'b0;
  endtask

  task automatic do_reset();
    po_data = 8'h00;
    step_tick = 1'b0;
    game_rst = 1'b0;
    sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (dir !== 2'd3)       begin errors++; $display("FAIL reset_dir got=%0d exp=3", dir); end
    checks++; if (paused !== 1'b0)     begin errors++; $display("FAIL reset_paused got=%0b exp=0", paused); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend got=%0b exp=0", pend_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (dir_upd !== 1'b0)    begin errors++; $display("FAIL reset_dir_upd got=%0b exp=0", dir_upd); end
    checks++; if (gesture_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", gesture_err); end
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_accept_commit();
    int busy_cnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(8'h01, i == 3, 1'b0);
      if (busy === 1'b1) busy_cnt++;
      if (i == 0) begin
        checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL t1_pend got=%0b exp=1", pend_valid); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL t1_busy got=%0b exp=1", busy); end
        checks++; if (dir !== 2'd3)        begin errors++; $display("FAIL t1_dir_pre got=%0d exp=3", dir); end
      end
      if (i == 3) begin
        checks++; if (dir !== 2'd0)        begin errors++; $display("FAIL t1_dir_commit got=%0d exp=0", dir); end
        checks++; if (dir_upd !== 1'b1)    begin errors++; $display("FAIL t1_dir_upd got=%0b exp=1", dir_upd); end
        checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL t1_pend_clr got=%0b exp=0", pend_valid); end
      end
      if (i == 4) begin
        checks++; if (dir_upd !== 1'b0)    begin errors++; $display("FAIL t1_dir_upd_pulse got=%0b exp=0", dir_upd); end
      end
    end
    checks++; if (busy_cnt != HOLD_CYC) begin errors++; $display("FAIL t1_busy_len got=%0d exp=%0d", busy_cnt, HOLD_CYC); end
  endtask

  task automatic test_reverse_err();
    do_reset();
    drive_cycle(8'h04, 1'b0, 1'b0);
    checks++; if (pend_valid !== 1'b0)  begin errors++; $display("FAIL t2_rev_pend got=%0b exp=0", pend_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL t2_rev_busy got=%0b exp=0", busy); end
    checks++; if (gesture_err !== 1'b0) begin errors++; $display("FAIL t2_rev_err got=%0b exp=0", gesture_err); end
    drive_cycle(8'h06, 1'b0, 1'b0);
    checks++; if (gesture_err !== 1'b1) begin errors++; $display("FAIL t2_err got=%0b exp=1", gesture_err); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL t2_err_busy got=%0b exp=0", busy); end
    drive_cycle(8'h06, 1'b0, 1'b0);
    checks++; if (gesture_err !== 1'b0) begin errors++; $display("FAIL t2_err_pulse got=%0b exp=0", gesture_err); end
  endtask

  task automatic test_holdoff_ignore();
    do_reset();
    drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h02, 1'b0, 1'b0);
    checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL t3_pend got=%0b exp=1", pend_valid); end
    for (int i = 0; i < 6; i++) drive_cycle(8'h02, 1'b0, 1'b0);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t3_busy_end got=%0b exp=0", busy); end
    drive_cycle(8'h02, 1'b0, 1'b0);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t3_no_refire got=%0b exp=0", busy); end
    drive_cycle(8'h02, 1'b1, 1'b0);
    checks++; if (dir !== 2'd0)        begin errors++; $display("FAIL t3_dir got=%0d exp=0", dir); end
    checks++; if (dir_upd !== 1'b1)    begin errors++; $display("FAIL t3_dir_upd got=%0b exp=1", dir_upd); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 6; i++) drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h02, 1'b1, 1'b0);
    checks++; if (dir !== 2'd0)        begin errors++; $display("FAIL t4_dir got=%0d exp=0", dir); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL t4_pend got=%0b exp=0", pend_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t4_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_pause();
    do_reset();
    drive_cycle(8'h10, 1'b0, 1'b0);
    checks++; if (paused !== 1'b1)     begin errors++; $display("FAIL t5_paused got=%0b exp=1", paused); end
    for (int i = 0; i < 5; i++) drive_cycle(8'h10, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b0, 1'b0);
    checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL t5_pend got=%0b exp=1", pend_valid); end
    for (int i = 0; i < 5; i++) drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b1, 1'b0);
    drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b1, 1'b0);
    checks++; if (dir !== 2'd3)        begin errors++; $display("FAIL t5_dir_held got=%0d exp=3", dir); end
    checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL t5_pend_held got=%0b exp=1", pend_valid); end
    checks++; if (dir_upd !== 1'b0)    begin errors++; $display("FAIL t5_no_upd got=%0b exp=0", dir_upd); end
    drive_cycle(8'h00, 1'b0, 1'b0);
    drive_cycle(8'h10, 1'b0, 1'b0);
    checks++; if (paused !== 1'b0)     begin errors++; $display("FAIL t5_unpause got=%0b exp=0", paused); end
    drive_cycle(8'h10, 1'b1, 1'b0);
    checks++; if (dir !== 2'd0)        begin errors++; $display("FAIL t5_dir got=%0d exp=0", dir); end
    checks++; if (dir_upd !== 1'b1)    begin errors++; $display("FAIL t5_dir_upd got=%0b exp=1", dir_upd); end
  endtask

  task automatic test_game_rst_async();
    do_reset();
    for (int i = 0; i < 6; i++) drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h10, 1'b0, 1'b0);
    checks++; if ({pend_valid, paused, busy} !== 3'b111) begin errors++; $display("FAIL t6_setup got=%03b exp=111", {pend_valid, paused, busy}); end
    drive_cycle(8'h02, 1'b0, 1'b1);
    checks++; if (dir !== 2'd3)        begin errors++; $display("FAIL t6_grst_dir got=%0d exp=3", dir); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL t6_grst_pend got=%0b exp=0", pend_valid); end
    checks++; if (paused !== 1'b0)     begin errors++; $display("FAIL t6_grst_paused got=%0b exp=0", paused); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t6_grst_busy got=%0b exp=0", busy); end
    drive_cycle(8'h02, 1'b0, 1'b0);
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL t6_grst_discard got=%0b exp=0", pend_valid); end
    drive_cycle(8'h00, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b0, 1'b0);
    drive_cycle(8'h01, 1'b0, 1'b0);
    checks++; if ({pend_valid, busy} !== 2'b11) begin errors++; $display("FAIL t6_pre_async got=%02b exp=11", {pend_valid, busy}); end
    #3 sys_rst_n = 1'b0;
    #1;
    checks++; if (dir !== 2'd3)        begin errors++; $display("FAIL t6_async_dir got=%0d exp=3", dir); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL t6_async_pend got=%0b exp=0", pend_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL t6_async_busy got=%0b exp=0", busy); end
    checks++; if ({paused, dir_upd, gesture_err} !== 3'b000) begin errors++; $display("FAIL t6_async_flags got=%03b exp=000", {paused, dir_upd, gesture_err}); end
    po_data = 8'h00;
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] pick[10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h06, 8'h20, 8'h81, 8'h00};
    logic [7:0] po;
    bit st, gr;
    do_reset();
    po = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        po = pick[$urandom_range(0, 9)];
        if (po == 8'h00 && $urandom_range(0, 1) == 1) po = 8'($urandom_range(0, 255));
      end
      st = ($urandom_range(0, 3) == 0);
      gr = ($urandom_range(0, 59) == 0);
      drive_cycle(po, st, gr);
      checks++; if (dir !== 2'(m_dir))                   begin errors++; $display("FAIL rnd_dir n=%0d got=%0d exp=%0d", n, dir, m_dir); end
      checks++; if (dir_upd !== m_upd)                   begin errors++; $display("FAIL rnd_dir_upd n=%0d got=%0b exp=%0b", n, dir_upd, m_upd); end
      checks++; if (paused !== m_paused)                 begin errors++; $display("FAIL rnd_paused n=%0d got=%0b exp=%0b", n, paused, m_paused); end
      checks++; if (pend_valid !== (m_pend.size() != 0)) begin errors++; $display("FAIL rnd_pend n=%0d got=%0b exp=%0b", n, pend_valid, m_pend.size() != 0); end
      checks++; if (busy !== (m_hold > 0))               begin errors++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, busy, m_hold > 0); end
      checks++; if (gesture_err !== m_err)               begin errors++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, gesture_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_accept_commit();
    test_reverse_err();
    test_holdoff_ignore();
    test_same_cycle();
    test_pause();
    test_game_rst_async();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gesture_dir_ctrl.md
Name: gesture_dir_ctrl

Overview:
Converts the raw PAJ7620 gesture byte (po_data from the I2C controller) into a validated snake heading for the snake engine.
- Detects new gestures, classifies them, rejects illegal reversals and applies a hold-off window.
- Queues one pending turn and commits it only on the engine's step tick.
- Forward gesture toggles pause.
- Sits between i2c_ctrl (upstream) and my_snake (downstream).

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
HOLDOFF_MS, 200, ignore window after an accepted gesture, in ms; HOLDOFF_CYC = CLK_FREQ/1000*HOLDOFF_MS, counter width = $clog2(HOLDOFF_CYC+1).
INIT_DIR, 2'd3, heading after reset or game restart (right).

Ports:
sys_clk  input  1  system clock.
sys_rst_n  input  1  asynchronous active-low reset.
po_data  input  8  raw gesture flags: b0 up, b1 down, b2 left, b3 right, b4 forward, b5..b7 other.
step_tick  input  1  one-cycle pulse from the snake engine at each move.
game_rst  input  1  synchronous restart request from the snake engine.
dir  output  2  committed heading: 0 up, 1 down, 2 left, 3 right.
dir_upd  output  1  one-cycle pulse when dir changes.
paused  output  1  level; the engine must not move while this is high.
pend_valid  output  1  a turn is queued.
busy  output  1  hold-off active.
gesture_err  output  1  one-cycle pulse for an unsupported or malformed gesture.

Behaviour:
- One clock (sys_clk). Reset is asynchronous and active-low (sys_rst_n).
- Reset values: dir=INIT_DIR, paused=0, pend_valid=0, pend_dir=INIT_DIR, busy=0, dir_upd=0, gesture_err=0, po_d=0, FSM=IDLE.
- po_d registers po_data every cycle in all states.
- event = (po_data != po_d) && (po_data != 0). A held, unchanged byte never re-fires.
- Classification (combinational on po_data):
  - DIR: po_data[7:4]==0 and po_data[3:0] is one-hot.
  - PAUSE: po_data==8'h10.
  - ERR: anything else nonzero.
- next_dir = (step_tick && pend_valid && !paused) ? pend_dir : dir.
- reverse(a,b) = (a[1]==b[1]) && (a[0]!=b[0]).
- FSM IDLE, on event:
  - DIR, not reverse(req, next_dir), req != next_dir: pend_dir<=req, pend_valid<=1 (overwrites any queued turn, latest wins) -> HOLDOFF.
  - DIR, reversed or same as next_dir: silently dropped, stay IDLE.
  - PAUSE: paused<=~paused -> HOLDOFF.
  - ERR: gesture_err=1 next cycle, stay IDLE, no hold-off.
- FSM HOLDOFF:
  - busy=1; counter runs 0..HOLDOFF_CYC-1, then -> IDLE with counter cleared.
  - Events are ignored: no err, no pend change.
- Commit (any state): if step_tick && pend_valid && !paused:
  - dir<=pend_dir, pend_valid<=0, dir_upd=1 in the following cycle.
- step_tick while paused: no commit, pending held.
- Same-cycle commit and accepted DIR event: old pending commits, new request becomes pending (pend_valid stays 1). The check against next_dir guarantees no 180-degree turn across consecutive steps.
- Latency:
  - po_data change at cycle N -> pend_valid/paused/busy at N+1.
  - step_tick at T -> dir and dir_upd at T+1.
- game_rst (highest priority): dir<=INIT_DIR, pend_valid<=0, paused<=0, counter<=0, FSM<=IDLE. Events and step_tick in that cycle are discarded. po_d still updates.
- Async reset mid-hold-off or with a queued turn restores all reset values immediately.

Decomposition:
- Shared package snake_pkg:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT (2-bit).
  - GES_UP=8'h01, GES_DOWN=8'h02, GES_LEFT=8'h04, GES_RIGHT=8'h08, GES_FWD=8'h10.
  - FSM state encoding: IDLE, HOLDOFF.
- One natural sub-module, ges_classify (combinational): po_data -> {is_dir, is_pause, is_err, req_dir}.
- Hold-off counter and commit logic stay in the top.

Test Plan:
All scenarios use CLK_FREQ=1000, HOLDOFF_MS=5 (HOLDOFF_CYC=5).
1. Reset, po_data 0->8'h01, step_tick 3 cycles later -> pend_valid=1 one cycle after the change, busy for 5 cycles; dir 3->0 and dir_upd pulse one cycle after step_tick.
2. dir=3, po_data=8'h04 (left, reverse) -> pend_valid stays 0, busy stays 0, gesture_err stays 0. Then po_data=8'h06 -> gesture_err one-cycle pulse, no busy.
3. po_data=8'h01 then 8'h02 two cycles later (inside hold-off) -> only up is queued. 8'h02 held until hold-off ends -> no second event (po_d already 8'h02).
4. dir=3, pending up; step_tick in the same cycle as po_data change to 8'h02 -> dir=0 at T+1, down rejected (reverse of next_dir), pend_valid=0.
5. po_data=8'h10 -> paused=1. Queue right->up, pulse step_tick twice -> dir stays 3, pend_valid=1. po_data 0 then 8'h10 after hold-off -> paused=0; next step_tick commits up.
6. Queued turn with paused=1 and busy=1, then game_rst pulse -> dir=3, pend_valid=0, paused=0, busy=0 next cycle. Assert sys_rst_n low mid-hold-off -> all outputs at reset values immediately.
